// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: zero-operand requests complete in one cycle.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      operation,
    input  logic [XLEN-1:0] in_0,
    input  logic [XLEN-1:0] in_1,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic            busy
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [2:0]          op, op_next;
    logic                neg, neg_next;
    logic [XLEN-1:0]     opa, opa_next;
    logic [2*XLEN-1:0]   acc, acc_next;
    logic [XLEN-1:0]     out_next;

    logic                is_div, sign_0, sign_1, neg_in, signed_ovf;
    logic [XLEN-1:0]     mag_0, mag_1;
    logic [XLEN:0]       mul_sum, div_trial;
    logic [2*XLEN-1:0]   step;

    // Apply the deferred sign to the magnitude result and pick the requested half.
    function automatic logic [XLEN-1:0] fix_sign(input logic [2:0] f_op, input logic f_neg,
                                                  input logic [2*XLEN-1:0] f_acc);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo, rem, res;
        prod = f_neg ? -f_acc : f_acc;
        quo  = f_neg ? -f_acc[XLEN-1:0] : f_acc[XLEN-1:0];
        rem  = f_neg ? -f_acc[2*XLEN-1:XLEN] : f_acc[2*XLEN-1:XLEN];
        case (f_op)
            3'd0:               res = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3:   res = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:         res = quo;
            default:            res = rem;
        endcase
        return res;
    endfunction

    assign is_div     = operation[2];
    assign sign_0     = (is_div ? ~operation[0] : (operation != 3'd3)) & in_0[XLEN-1];
    assign sign_1     = (is_div ? ~operation[0] : ~operation[1]) & in_1[XLEN-1];
    assign mag_0      = sign_0 ? -in_0 : in_0;
    assign mag_1      = sign_1 ? -in_1 : in_1;
    // Remainder follows the dividend; everything else follows the product of signs.
    assign neg_in     = (is_div && operation[1]) ? sign_0 : (sign_0 ^ sign_1);
    assign signed_ovf = is_div && !operation[0] && (in_0 == {1'b1, {(XLEN-1){1'b0}}})
                        && (in_1 == {XLEN{1'b1}});

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opa} : '0);
        div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opa};
        if (!op[2])
            step = {mul_sum, acc[XLEN-1:1]};
        else if (!div_trial[XLEN])
            step = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            step = {acc[2*XLEN-2:0], 1'b0};
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        op_next    = op;
        neg_next   = neg;
        opa_next   = opa;
        acc_next   = acc;
        out_next   = out;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    op_next    = operation;
                    neg_next   = neg_in;
                    opa_next   = is_div ? mag_1 : mag_0;
                    acc_next   = {{XLEN{1'b0}}, (is_div ? mag_0 : mag_1)};
                    cnt_next   = CNT_INIT;
                    state_next = CALC;
                    if (is_div && (in_1 == '0)) begin
                        cnt_next   = '0;
                        state_next = DONE;
                        out_next   = operation[1] ? in_0 : {XLEN{1'b1}};
                    end else if (signed_ovf) begin
                        cnt_next   = '0;
                        state_next = DONE;
                        out_next   = operation[1] ? '0 : in_0;
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    else if ((!is_div && ((in_0 == '0) || (in_1 == '0))) ||
                             (is_div && (in_0 == '0))) begin
                        cnt_next   = '0;
                        state_next = DONE;
                        out_next   = '0;
                    end
`else
                    else begin
                        state_next = CALC;
                    end
`endif
                end
            end
            CALC: begin
                acc_next = step;
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_next = DONE;
                    out_next   = fix_sign(op, neg, step);
                end
            end
            DONE: begin
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            op    <= '0;
            neg   <= 1'b0;
            opa   <= '0;
            acc   <= '0;
            out   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            op    <= op_next;
            neg   <= neg_next;
            opa   <= opa_next;
            acc   <= acc_next;
            out   <= out_next;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed plan steps plus randomized ops vs a 64-bit arithmetic model.
module tb_muldiv_unit;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  operation;
    logic [31:0] in_0;
    logic [31:0] in_1;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        busy;

    int tests;
    int failed;
    int lat;

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operation (operation),
        .in_0      (in_0),
        .in_1      (in_1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Architectural result computed with wide integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (op)
            3'd0: begin p = sa * sb;           return p[31:0];  end
            3'd1: begin p = sa * sb;           return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub;           return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 32'd0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (!op[2] && (a == 32'd0 || b == 32'd0)) return 1;
        if (op[2] && a == 32'd0) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_out();
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, " ready"}, 64'(in_ready), 64'd1);
        operation = op;
        in_0      = a;
        in_1      = b;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_0      = $urandom;
        in_1      = $urandom;
        operation = 3'($urandom);
        wait_out();
        check({tag, " latency"}, 64'(lat), 64'(ref_lat(op, a, b)));
        check({tag, " result"}, 64'(out), 64'(ref_result(op, a, b)));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " idle after handshake"}, {62'd0, in_ready, out_valid}, 64'd2);
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        operation = 3'd0;
        in_0      = '0;
        in_1      = '0;
        #1;
        check("reset state", {60'd0, in_ready, out_valid, busy, |out}, 64'h8);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("MUL 5x7", 3'd0, 32'd5, 32'd7);
        run_op("MULH -2x3", 3'd1, 32'hFFFFFFFE, 32'd3);
        run_op("MULHU max", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("MULHSU -1x2", 3'd2, 32'hFFFFFFFF, 32'd2);
        run_op("DIV -7/2", 3'd4, 32'hFFFFFFF9, 32'd2);
        run_op("REM -7/2", 3'd6, 32'hFFFFFFF9, 32'd2);
        run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7);
        run_op("REMU 100/7", 3'd7, 32'd100, 32'd7);
        run_op("DIV 9/0", 3'd4, 32'd9, 32'd0);
        run_op("REM 9/0", 3'd6, 32'd9, 32'd0);
        run_op("DIV ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF);
        run_op("REM ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF);
        run_op("MUL 0x123", 3'd0, 32'd0, 32'd123);
        run_op("DIVU 0/5", 3'd5, 32'd0, 32'd5);

        // Backpressure with in_valid held high through CALC and DONE
        operation = 3'd0;
        in_0      = 32'd6;
        in_1      = 32'd9;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_0 = 32'd1;
        in_1 = 32'd1;
        wait_out();
        check("bp latency", 64'(lat), 64'd33);
        check("bp result", 64'(out), 64'd54);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp out stable", 64'(out), 64'd54);
            check("bp ready low / valid high", {62'd0, in_ready, out_valid}, 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp idle after handshake", {61'd0, in_ready, out_valid, busy}, 64'd4);

        // Reset in the middle of a DIVU
        operation = 3'd5;
        in_0      = 32'd1000;
        in_1      = 32'd7;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        check("mid-op busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid-op reset", {60'd0, in_ready, out_valid, busy, |out}, 64'h8);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("after reset idle", {61'd0, in_ready, out_valid, busy}, 64'd4);
        run_op("MUL 3x4 after reset", 3'd0, 32'd3, 32'd4);

        for (int i = 0; i < 48; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            run_op($sformatf("rnd%0d op%0d %h %h", i, op, a, b), op, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
